decoder_n_seq: RTL and testbench



---
 rtl/decoder_pkg.sv | 20 ++
 rtl/decoder_n_comb.sv | 16 +
 rtl/decoder_n_seq.sv | 122 ++++++++++++
 tb/tb_decoder_n_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder family.
package decoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    localparam int unsigned DEC_N    = 5;
    localparam int unsigned DEC_OUTS = 1 << DEC_N;

    // Fixed-width helper for blocks built around the default select width.
    function automatic logic [DEC_OUTS-1:0] onehot(input logic [DEC_N-1:0] idx, input logic en);
        onehot = en ? (DEC_OUTS'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/decoder_n_comb.sv
// Purely combinational N-to-2^N one-hot decode with enable; all-zero when disabled.
import decoder_pkg::*;

module decoder_n_comb #(
    parameter int unsigned N = DEC_N
) (
    input  logic [N-1:0]        sel_i,
    input  logic                en_i,
    output logic [(1<<N)-1:0]   word_o
);

    for (genvar gi = 0; gi < (1 << N); gi++) begin : g_bit
        assign word_o[gi] = en_i && (sel_i == N'(gi));
    end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered N-to-2^N decoder with valid/ready on both sides and a sweep mode.
// Optional build macro DECODER_ACTIVE_LOW_EN makes out_q one-cold (reset/disabled = all ones).
import decoder_pkg::*;

module decoder_n_seq #(
    parameter int unsigned N            = DEC_N,
    parameter int unsigned SWEEP_STRIDE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_sel,
    input  logic                 in_en,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(1<<N)-1:0]    out_q,
    output logic [N-1:0]         out_idx,
    output logic                 out_last,
    output logic                 busy
);

    localparam int unsigned OUTS    = 1 << N;
    localparam logic [N:0]  STRIDE_W = (N+1)'(SWEEP_STRIDE);
    localparam logic [N:0]  TOP_IDX  = (N+1)'(OUTS - 1);
`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUTS-1:0] POL_MASK = '1;
`else
    localparam logic [OUTS-1:0] POL_MASK = '0;
`endif

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic              en_q,    en_d;
    logic [N-1:0]      idx_q,   idx_d;
    logic [OUTS-1:0]   word_q,  word_d;

    logic              accept, beat;
    logic [N:0]        start_sum, step_sum, next_sum;
    logic [N-1:0]      next_idx;
    logic              start_last, next_last;
    logic [N-1:0]      dec_sel;
    logic              dec_en;
    logic [OUTS-1:0]   dec_word;

    // state_q==SWEEP means more sweep beats remain after the one on the output;
    // the final sweep beat is shown from IDLE so a new request can load on its edge.
    assign in_ready  = (state_q == IDLE) && (!valid_q || (out_ready && last_q));
    assign accept    = in_valid && in_ready;
    assign beat      = valid_q && out_ready;

    // Sums carry one extra bit so the end-of-sweep test never wraps.
    assign start_sum  = {1'b0, in_sel} + STRIDE_W;
    assign start_last = start_sum > TOP_IDX;
    assign step_sum   = {1'b0, idx_q} + STRIDE_W;
    assign next_idx   = step_sum[N-1:0];
    assign next_sum   = {1'b0, next_idx} + STRIDE_W;
    assign next_last  = next_sum > TOP_IDX;

    assign dec_sel = accept ? in_sel : next_idx;
    assign dec_en  = accept ? in_en  : en_q;

    decoder_n_comb #(.N(N)) u_comb (
        .sel_i  (dec_sel),
        .en_i   (dec_en),
        .word_o (dec_word)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        en_d    = en_q;
        idx_d   = idx_q;
        word_d  = word_q;
        if (accept) begin
            valid_d = 1'b1;
            word_d  = dec_word ^ POL_MASK;
            idx_d   = in_sel;
            en_d    = in_en;
            last_d  = (in_mode == MODE_SINGLE) || start_last;
            state_d = ((in_mode == MODE_SWEEP) && !start_last) ? SWEEP : IDLE;
        end else if (beat) begin
            if (state_q == SWEEP) begin
                word_d  = dec_word ^ POL_MASK;
                idx_d   = next_idx;
                last_d  = next_last;
                state_d = next_last ? IDLE : SWEEP;
            end else begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            en_q    <= 1'b0;
            idx_q   <= '0;
            word_q  <= POL_MASK;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            en_q    <= en_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    assign out_valid = valid_q;
    assign out_q     = word_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign busy      = (state_q == SWEEP);

endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed self-checking bench for decoder_n_seq (stride-1 and stride-8 instances).
module tb_decoder_n_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid8;
    logic [4:0]  in_sel;
    logic        in_en, in_mode, out_ready;

    logic        in_ready, out_valid, out_last, busy;
    logic [31:0] out_q;
    logic [4:0]  out_idx;
    logic        in_ready8, out_valid8, out_last8, busy8;
    logic [31:0] out_q8;
    logic [4:0]  out_idx8;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [31:0] RST_WORD = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] RST_WORD = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    decoder_n_seq #(.N(5), .SWEEP_STRIDE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_en(in_en), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    decoder_n_seq #(.N(5), .SWEEP_STRIDE(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_sel(in_sel),
        .in_en(in_en), .in_mode(in_mode),
        .out_valid(out_valid8), .out_ready(out_ready), .out_q(out_q8),
        .out_idx(out_idx8), .out_last(out_last8), .busy(busy8)
    );

    function automatic logic [31:0] exp_word(input int sel, input logic en);
        logic [31:0] w;
        w = en ? (32'h1 << sel) : 32'h0;
`ifdef DECODER_ACTIVE_LOW_EN
        w = ~w;
`endif
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
        in_sel = '0; in_en = 1'b1; in_mode = 1'b0; out_ready = 1'b1;

        // Reset values
        #12;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_q",     64'(out_q), 64'(RST_WORD));
        check_eq("rst_idx",   64'(out_idx), 64'd0);
        check_eq("rst_last",  64'(out_last), 64'd0);
        check_eq("rst_busy",  64'(busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // SINGLE, back-to-back selects 0..31
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_en = 1'b1; in_sel = 5'(i);
            @(negedge clk);
            check_eq("single_rdy", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            $display("single sel=%0d out_q=%08h idx=%0d last=%0b", i, out_q, out_idx, out_last);
            check_eq("single_valid", 64'(out_valid), 64'd1);
            check_eq("single_q",     64'(out_q), 64'(exp_word(i, 1'b1)));
            check_eq("single_idx",   64'(out_idx), 64'(i));
            check_eq("single_last",  64'(out_last), 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("drain_valid", 64'(out_valid), 64'd0);

        // SINGLE sel=7 under backpressure
        in_valid = 1'b1; in_sel = 5'd7; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("stall_valid", 64'(out_valid), 64'd1);
            check_eq("stall_q",     64'(out_q), 64'(exp_word(7, 1'b1)));
            check_eq("stall_rdy",   64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("stall_release_rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        $display("stall sel=7 completed, out_valid=%0b", out_valid);
        check_eq("stall_one_beat", 64'(out_valid), 64'd0);

        // SWEEP from 28, stride 1, with a SINGLE sel=5 loading on the final beat
        in_valid = 1'b1; in_mode = 1'b1; in_sel = 5'd28; in_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 28; k < 32; k++) begin
            @(negedge clk);
            $display("sweep idx=%0d out_q=%08h last=%0b busy=%0b", out_idx, out_q, out_last, busy);
            check_eq("sweep_q",    64'(out_q), 64'(exp_word(k, 1'b1)));
            check_eq("sweep_idx",  64'(out_idx), 64'(k));
            check_eq("sweep_last", 64'(out_last), 64'(k == 31));
            check_eq("sweep_busy", 64'(busy), 64'(k != 31));
            if (k == 31) begin
                in_valid = 1'b1; in_mode = 1'b0; in_sel = 5'd5;
                #1;
                check_eq("sweep_end_rdy", 64'(in_ready), 64'd1);
            end else begin
                check_eq("sweep_rdy", 64'(in_ready), 64'd0);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("nogap_valid", 64'(out_valid), 64'd1);
        check_eq("nogap_q",     64'(out_q), 64'(exp_word(5, 1'b1)));
        check_eq("nogap_idx",   64'(out_idx), 64'd5);
        @(posedge clk); #1;
        check_eq("nogap_drain", 64'(out_valid), 64'd0);

        // Stride-8 SWEEP from 0 with enable off
        in_valid8 = 1'b1; in_mode = 1'b1; in_sel = 5'd0; in_en = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            $display("sweep8 idx=%0d out_q=%08h last=%0b", out_idx8, out_q8, out_last8);
            check_eq("s8_valid", 64'(out_valid8), 64'd1);
            check_eq("s8_q",     64'(out_q8), 64'(exp_word(8 * k, 1'b0)));
            check_eq("s8_idx",   64'(out_idx8), 64'(8 * k));
            check_eq("s8_last",  64'(out_last8), 64'(k == 3));
            @(posedge clk); #1;
        end
        check_eq("s8_drain", 64'(out_valid8), 64'd0);

        // Asynchronous reset in the middle of a sweep
        in_valid = 1'b1; in_mode = 1'b1; in_sel = 5'd0; in_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_idx",  64'(out_idx), 64'd10);
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-sweep: valid=%0b q=%08h busy=%0b", out_valid, out_q, busy);
        check_eq("arst_valid", 64'(out_valid), 64'd0);
        check_eq("arst_q",     64'(out_q), 64'(RST_WORD));
        check_eq("arst_busy",  64'(busy), 64'd0);
        check_eq("arst_last",  64'(out_last), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check_eq("post_rst_rdy", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_mode = 1'b0; in_sel = 5'd3; in_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("single sel=3 after reset out_q=%08h", out_q);
        check_eq("post_rst_valid", 64'(out_valid), 64'd1);
        check_eq("post_rst_q",     64'(out_q), 64'(exp_word(3, 1'b1)));
        check_eq("post_rst_last",  64'(out_last), 64'd1);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
